// File: rtl/rv_mtimer_if.sv
// Data-memory bus between the core (master) and the machine-timer peripheral (slave).
// Handshake: a request (sel & (mem_read_mem | mem_write_mem)) seen while the slave is idle is
// accepted that cycle; stall_pipl is its combinational acknowledgement, the store lands and the
// load data is registered at the closing edge, and the following cycle ignores all bus inputs.
interface rv_mtimer_if;
  logic        sel;
  logic [31:0] mem_addr_mem;
  logic [31:0] mem_wdata_mem;
  logic        mem_write_mem;
  logic        mem_read_mem;
  logic [2:0]  mem_op_mem;
  logic [31:0] mem_rdata_mem;
  logic        stall_pipl;

  modport master (
    output sel, mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem,
    input  mem_rdata_mem, stall_pipl
  );

  modport slave (
    input  sel, mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem,
    output mem_rdata_mem, stall_pipl
  );
endinterface

// File: rtl/rv_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp behind the data-memory bus, level timer_int on mtime >= mtimecmp.
// Optional clock divisor enabled by defining RV_MTIMER_PRESCALE_EN.
module rv_mtimer #(
  parameter int PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  rv_mtimer_if.slave bus,
  output logic       timer_int,
  output logic       fsm_state
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t      state, state_next;
  logic        accept;
  logic [63:0] mtime, mtimecmp;
  logic [1:0]  ctrl;
  logic [31:0] rdata;
  logic        tick, hit;
  logic [2:0]  idx;
  logic [1:0]  off;
  logic        op_ok, aligned, access_ok, store_en;
  logic [3:0]  byte_mask;
  logic [31:0] rd_word, shifted, load_data, wdata_lane, merged, prescale_word;
  logic        unused_addr;

  assign idx         = bus.mem_addr_mem[4:2];
  assign off         = bus.mem_addr_mem[1:0];
  assign unused_addr = ^bus.mem_addr_mem[31:5];

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (bus.sel && (bus.mem_read_mem || bus.mem_write_mem)) begin
        accept     = 1'b1;
        state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign bus.stall_pipl = accept & ~reset;
  assign fsm_state      = (state == ACK);

  // Size and alignment decode shared by loads and stores.
  always_comb begin
    op_ok     = 1'b0;
    aligned   = 1'b0;
    byte_mask = 4'b0000;
    case (bus.mem_op_mem)
      3'b000, 3'b100: begin
        op_ok     = 1'b1;
        aligned   = 1'b1;
        byte_mask = 4'b0001 << off;
      end
      3'b001, 3'b101: begin
        op_ok     = 1'b1;
        aligned   = ~off[0];
        byte_mask = 4'b0011 << off;
      end
      3'b010: begin
        op_ok     = 1'b1;
        aligned   = (off == 2'd0);
        byte_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  assign access_ok = op_ok & aligned;
  assign store_en  = accept & bus.mem_write_mem & access_ok;
  assign hit       = (mtime >= mtimecmp);

`ifdef RV_MTIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale, pcnt;

  assign tick          = ctrl[0] && (pcnt == prescale);
  assign prescale_word = 32'(prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (store_en && idx == 3'd5) prescale <= merged[PRESCALE_W-1:0];
      if (ctrl[0]) pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end
`else
  assign tick          = ctrl[0];
  assign prescale_word = 32'd0;
`endif

  always_comb begin
    rd_word = 32'd0;
    case (idx)
      3'd0:    rd_word = mtime[31:0];
      3'd1:    rd_word = mtime[63:32];
      3'd2:    rd_word = mtimecmp[31:0];
      3'd3:    rd_word = mtimecmp[63:32];
      3'd4:    rd_word = {30'd0, ctrl};
      3'd5:    rd_word = prescale_word;
      3'd6:    rd_word = {31'd0, hit};
      default: rd_word = 32'd0;
    endcase
  end

  assign shifted = rd_word >> {off, 3'b000};

  always_comb begin
    load_data = 32'd0;
    if (access_ok) begin
      case (bus.mem_op_mem)
        3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
        3'b100:  load_data = {24'd0, shifted[7:0]};
        3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
        3'b101:  load_data = {16'd0, shifted[15:0]};
        3'b010:  load_data = rd_word;
        default: load_data = 32'd0;
      endcase
    end
  end

  // Store data is moved onto its lanes and merged over the current register word.
  assign wdata_lane = bus.mem_wdata_mem << {off, 3'b000};

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_mask[i]) merged[8*i +: 8] = wdata_lane[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime     <= 64'd0;
      mtimecmp  <= '1;
      ctrl      <= 2'b00;
      rdata     <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      // A store to either mtime half wins over a coincident tick; no carry into the other half.
      if (store_en && idx == 3'd0)      mtime <= {mtime[63:32], merged};
      else if (store_en && idx == 3'd1) mtime <= {merged, mtime[31:0]};
      else if (tick)                    mtime <= mtime + 64'd1;
      if (store_en && idx == 3'd2) mtimecmp[31:0]  <= merged;
      if (store_en && idx == 3'd3) mtimecmp[63:32] <= merged;
      if (store_en && idx == 3'd4) ctrl <= merged[1:0];
      if (accept && bus.mem_read_mem) rdata <= load_data;
      timer_int <= ctrl[1] & hit;
    end
  end

  assign bus.mem_rdata_mem = rdata;

endmodule

// File: doc/rv_mtimer.md
# rv_mtimer

Machine-timer peripheral that answers the core's data-memory bus and drives the core's `timer_int` line. It holds a 64-bit free-running `mtime` and a 64-bit `mtimecmp`, and raises the interrupt while `mtime >= mtimecmp`. It sits behind the SoC address decoder, which asserts `sel`, and returns read data plus a bus stall using the same op encoding the core emits.

## Interface
- `PRESCALE_W`, 16: width of the prescale divisor register.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high reset.
- `sel` in 1: address decoder hit for this block.
- `mem_addr_mem` in 32: byte address; only bits [4:0] are used.
- `mem_wdata_mem` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `mem_write_mem` in 1: store request.
- `mem_read_mem` in 1: load request.
- `mem_op_mem` in 3: funct3 encoding. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `mem_rdata_mem` out 32: load data, right-aligned and extended.
- `stall_pipl` out 1: holds the core pipeline during the access cycle.
- `timer_int` out 1: machine timer interrupt, level-sensitive.

## Operation
- Register map (byte offsets):
  - 0x00 `mtime_lo`
  - 0x04 `mtime_hi`
  - 0x08 `mtimecmp_lo`
  - 0x0C `mtimecmp_hi`
  - 0x10 `ctrl`: bit0 = count enable, bit1 = irq enable.
  - 0x14 `prescale`: [PRESCALE_W-1:0].
  - 0x18 `status`: bit0 = compare hit, read-only.
  - Offset 0x1C reads 0 and ignores writes.
- Reset values:
  - `mtime` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `ctrl` = 0.
  - `prescale` = 0.
  - Prescale counter = 0.
  - `mem_rdata_mem` = 0, `timer_int` = 0.
  - FSM = IDLE.
- FSM has two states:
  - IDLE to ACK on `sel & (mem_read_mem | mem_write_mem)`.
  - ACK to IDLE unconditionally. All bus inputs are ignored while in ACK.
- Stores:
  - Byte lane(s) are selected by `mem_addr_mem[1:0]`.
  - SB writes any lane. SH writes lanes {1,0} or {3,2}. SW writes all four lanes.
  - Misaligned SH (addr[0]=1) or SW (addr[1:0]≠0) is dropped with no register change.
  - The store takes effect at the clock edge ending the IDLE request cycle.
- Loads:
  - The addressed word is shifted right by the lane offset.
  - B/H are sign-extended; BU/HU are zero-extended; W is unmodified.
  - A misaligned load returns 0.
  - Unsupported op codes (011, 110, 111) read 0 and drop writes.
- Counting:
  - A tick is generated when `ctrl[0]` is set and the prescale counter equals `prescale`.
  - On a tick the counter clears; otherwise it increments.
  - `mtime` increments by 1 per tick and wraps from 2^64−1 to 0.
  - While `ctrl[0]` is 0 the prescale counter holds.
- Write vs. tick collision: a store to `mtime_lo` or `mtime_hi` in the same cycle as a tick takes the written half and suppresses that tick's increment on both halves. No carry is applied.
- Compare: `hit` = (`mtime` >= `mtimecmp`), unsigned 64-bit, evaluated on current register values.
- Interrupt: `timer_int` is registered as `ctrl[1] & hit`. It stays high until software raises `mtimecmp`, clears `ctrl[1]`, or `mtime` wraps below `mtimecmp`.
- `status[0]` = `hit`, independent of `ctrl[1]`.

## Timing
- An access is accepted in cycle N (IDLE).
  - `stall_pipl` = 1 combinationally in cycle N.
  - Load data is registered at the end of N and valid in N+1.
  - `stall_pipl` = 0 in N+1.
- Each access occupies 2 cycles. Back-to-back requests are accepted at N, N+2, N+4, …
- `stall_pipl` is 0 whenever there is no request, in ACK, and during reset.
- Interrupt latency: `timer_int` rises 1 cycle after `hit` becomes true. After a `mtimecmp` store makes `hit` false, it falls in N+2.
- Load of `mtime_lo` returns the value before any tick at the end of cycle N.
- `reset` asserted mid-access (in ACK) returns to IDLE next cycle, clears all registers, and leaves `stall_pipl` low.

## Configuration
- `RV_MTIMER_PRESCALE_EN`:
  - Defined: the `prescale` register and prescale counter are implemented as described.
  - Undefined: no divisor logic. A tick occurs every cycle while `ctrl[0]` = 1, offset 0x14 reads 0, and writes to it are dropped.

## Test plan
- Reset, then LW of all offsets:
  - 0x08 and 0x0C return 32'hFFFFFFFF; all others return 0.
  - `timer_int` = 0.
  - `stall_pipl` is high exactly 1 cycle per access.
- SW 0x10 = 3, `prescale` = 0, SW `mtimecmp_lo` = 10, `mtimecmp_hi` = 0: `timer_int` rises when `mtime` = 10, one cycle after the compare goes true. A subsequent SW of 0x08 = 100 drops `timer_int` 2 cycles after acceptance.
- SB 0x09 = 8'hAB, then LB 0x09 and LBU 0x09:
  - LB returns 32'hFFFFFFAB; LBU returns 32'h000000AB.
  - `mtimecmp_lo` reads 32'hFFFFABFF.
  - SH at 0x01 and LW at 0x02 are dropped and return 0.
- Set `mtime` = 64'h0000_0000_FFFF_FFFF, enable counting: the next tick gives `mtime_hi` = 1, `mtime_lo` = 0. From 64'hFFFF…FFFF the next tick wraps to 0.
- With `prescale` = 3, `ctrl[0]` = 1: `mtime` advances once every 4 cycles. Store `mtime_lo` = 5 on a tick cycle: it reads 5, not 6.
- Assert `reset` in an ACK cycle of a load: next cycle is IDLE with `mem_rdata_mem` = 0 and all registers at reset values.
